// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a latched PATTERN_W-bit pattern MSB-first,
// repeated N times (0 = until abort) with an optional idle gap between frames.
module seq_generator #(
  parameter int PATTERN_W = 4,
  parameter int COUNT_W   = 8,
  parameter int GAP_W     = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [COUNT_W-1:0]   repeat_count,
  input  logic [GAP_W-1:0]     gap_cycles,
  output logic                 sequence_out,
  output logic                 bit_valid,
  output logic                 frame_start,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] sh_q, sh_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]     gcfg_q, gcfg_d;
  logic [GAP_W-1:0]     gcnt_q, gcnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 seq_q, seq_d;
  logic                 vld_q, vld_d;
  logic                 fs_q, fs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 go;
  logic [PATTERN_W-1:0] go_pat;
  logic                 last_bit;
  logic                 last_frame;

  assign last_bit   = (idx_q == IDX_W'(PATTERN_W - 1));
  assign last_frame = (cnt_q == COUNT_W'(1));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gcfg_d  = gcfg_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    seq_d   = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    go      = 1'b0;
    go_pat  = pat_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pat_d  = pattern_in;
          cnt_d  = repeat_count;
          gcfg_d = gap_cycles;
          go     = 1'b1;
          go_pat = pattern_in;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!last_bit) begin
          idx_d  = idx_q + 1'b1;
          seq_d  = sh_q[PATTERN_W-1];
          sh_d   = sh_q << 1;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else if (last_frame) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          // A zero count means continuous mode, so it is never decremented.
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (gcfg_q == '0) begin
            go = 1'b1;
          end else begin
            state_d = GAP;
            gcnt_d  = gcfg_q;
            busy_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gcnt_q == GAP_W'(1)) begin
          go = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Common frame launch: first bit goes out directly, the rest are shifted.
    if (go) begin
      state_d = SHIFT;
      idx_d   = '0;
      seq_d   = go_pat[PATTERN_W-1];
      sh_d    = go_pat << 1;
      vld_d   = 1'b1;
      fs_d    = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      gcfg_q  <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      seq_q   <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gcfg_q  <= gcfg_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sequence_out = seq_q;
  assign bit_valid    = vld_q;
  assign frame_start  = fs_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
